keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//   Behavioural-synthesizable 4x4 keypad model: the switch-matrix side of the keypad scan interface.
//   Observes the active-low row drive from the keypad scanner and returns active-low sense lines
//   as a real pressed key would, including contact bounce, hold time and release gap.
//   Used in FPGA self-test and the scanner testbench, attached to the scanner's scan/sense pins.
// PARAMETERS
//   BOUNCE_CYCLES  40    cycles of bouncing contact after press (0 = no bounce phase)
//   BOUNCE_PERIOD  4     cycles per contact level while bouncing (>=1)
//   HOLD_CYCLES    1000  cycles the contact is held solidly closed (>=1)
//   GAP_CYCLES     200   cycles the contact is open after release, before done (>=1)
//   All cycle parameters <= 65535 (16-bit phase counter)
// PORTS
//   clk        in   1  clock
//   rst        in   1  asynchronous, active-high reset
//   key_code   in   4  key to press: 0-9 digits, A-D letters, E = '*', F = '#'
//   press_req  in   1  start a press of key_code (sampled only in IDLE)
//   abort      in   1  cancel the press in progress immediately
//   scan_in    in   4  row drive from scanner, active-low one-hot (0111,1011,1101,1110)
//   sense_out  out  4  column sense to scanner, active-low; 1111 = no contact
//   busy       out  1  press sequence in progress
//   done       out  1  one-cycle pulse: sequence completed normally
//   contact    out  1  current switch state (1 = closed), for debug
// BEHAVIOUR
//   Reset: state IDLE, busy=0, done=0, contact=0, sense_out=1111, latched row/col = 1111.
//   Key map (row pattern, column pattern), patterns R0=0111 R1=1011 R2=1101 R3=1110:
//     row R0: 1,2,3,A  row R1: 4,5,6,B  row R2: 7,8,9,C  row R3: E,0,F,D  (columns R0..R3 in order)
//   sense_out is combinational: = col pattern when contact=1 AND scan_in == row pattern exactly;
//     otherwise 1111 (multi-hot, all-high or non-matching scan_in -> 1111).
//   FSM states IDLE, BOUNCE, HOLD, GAP; 16-bit counter cnt cleared on every state entry.
//   IDLE: press_req=1 & abort=0 -> latch row/col from key_code, busy=1 next cycle,
//     go BOUNCE (or HOLD if BOUNCE_CYCLES=0). press_req while busy is ignored (no queueing).
//   BOUNCE: lasts BOUNCE_CYCLES cycles; contact = ~((cnt / BOUNCE_PERIOD) & 1), first level closed.
//   HOLD: lasts HOLD_CYCLES cycles, contact=1.
//   GAP: lasts GAP_CYCLES cycles, contact=0; on exit -> IDLE, done=1 for exactly that first IDLE
//     cycle, busy=0 in the same cycle. A new press_req in that cycle is accepted.
//   Total latency press_req edge -> done = BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES+1 cycles.
//   abort=1 in any non-IDLE state: next cycle IDLE, contact=0, busy=0, no done pulse.
//     abort and press_req together in IDLE: abort wins, request dropped.
//   key_code changes after acceptance have no effect until the next accepted press.
//   rst mid-sequence: immediate return to reset values, no done pulse.
//   contact, busy, done are registered; cnt saturates never (bounded by parameters).
// TESTING (params B=4, P=2, H=6, G=3 unless stated)
//   1. press_req at edge 0, key_code=5, scan_in=1011 held -> sense_out 1011,1011,1111,1111 in
//      cycles 1-4, 1011 cycles 5-10, 1111 cycles 11-13; done=1 and busy=0 at cycle 14 only.
//   2. Full key map: for all 16 codes, scan rows cycling each cycle -> sense_out != 1111 only
//      while scan_in matches mapped row; value equals mapped column (E->R3/0111, 0->R3/1011).
//   3. scan_in=0011 or 1111 during HOLD of key 1 -> sense_out=1111; scan_in=0111 -> 0111.
//   4. press_req for key 9 asserted at cycle 3 of an active press -> ignored; single done at 14.
//   5. abort at cycle 7 (HOLD) -> cycle 8 busy=0, contact=0, sense_out=1111, done never pulses.
//   6. rst asserted mid-HOLD -> outputs at reset values immediately; with BOUNCE_CYCLES=0 a new
//      press shows contact=1 from cycle 1 and done at cycle H+G+1 = 10.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Switch-matrix side of a 4x4 keypad. Watches the scanner's active-low row
//   drive and answers on the active-low column sense lines the way a real key
//   would: a bouncing contact, then a solid hold, then an open release gap.
//
//   clk        clock
//   rst        asynchronous, active-high reset
//   key_code   key to press (0-9, A-D, E='*', F='#')
//   press_req  start a press; only looked at while idle
//   abort      drop the press in progress (no done pulse)
//   scan_in    row drive from scanner, active-low one-hot
//   sense_out  column sense to scanner, active-low, 1111 = open
//   busy       press sequence in progress
//   done       one-cycle pulse when a sequence completes normally
//   contact    current switch state (1 = closed)
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 40,
  parameter int BOUNCE_PERIOD = 4,
  parameter int HOLD_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       press_req,
  input  logic       abort,
  input  logic [3:0] scan_in,
  output logic [3:0] sense_out,
  output logic       busy,
  output logic       done,
  output logic       contact
);

  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;

  localparam logic [15:0] B_LAST = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] H_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] B_PER  = 16'(BOUNCE_PERIOD);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  row_q, row_d, col_q, col_d;
  logic        busy_q, busy_d, done_q, done_d, contact_q, contact_d;
  logic [15:0] bounce_lvl;
  logic [7:0]  map;

  // {row pattern, column pattern} for the requested key
  always_comb begin
    case (key_code)
      4'h1: map = 8'b0111_0111;
      4'h2: map = 8'b0111_1011;
      4'h3: map = 8'b0111_1101;
      4'hA: map = 8'b0111_1110;
      4'h4: map = 8'b1011_0111;
      4'h5: map = 8'b1011_1011;
      4'h6: map = 8'b1011_1101;
      4'hB: map = 8'b1011_1110;
      4'h7: map = 8'b1101_0111;
      4'h8: map = 8'b1101_1011;
      4'h9: map = 8'b1101_1101;
      4'hC: map = 8'b1101_1110;
      4'hE: map = 8'b1110_0111;
      4'h0: map = 8'b1110_1011;
      4'hF: map = 8'b1110_1101;
      default: map = 8'b1110_1110; // 4'hD
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (press_req && !abort) begin
          {row_d, col_d} = map;
          state_d = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE;
        end
      end
      BOUNCE: if (cnt_q == B_LAST) state_d = HOLD;
      HOLD:   if (cnt_q == H_LAST) state_d = GAP;
      GAP: if (cnt_q == G_LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // abort beats a normal completion in the same cycle
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    if (state_d != state_q) cnt_d = 16'd0;
  end

  // outputs are registered, so derive them from the next state/count
  always_comb begin
    bounce_lvl = cnt_d / B_PER;
    busy_d     = (state_d != IDLE);
    case (state_d)
      BOUNCE:  contact_d = ~bounce_lvl[0];
      HOLD:    contact_d = 1'b1;
      default: contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      row_q     <= 4'hF;
      col_q     <= 4'hF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      contact_q <= contact_d;
    end
  end

  // exact match only: multi-hot or idle scan patterns never see a contact
  assign sense_out = (contact_q && scan_in == row_q) ? col_q : 4'hF;
  assign busy      = busy_q;
  assign done      = done_q;
  assign contact   = contact_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (with and without a bounce phase)
// checked every cycle against a press-timeline model, plus directed scenarios.
module tb_keypad_emulator;

  localparam int P = 2, H = 6, G = 3;
  localparam int BCFG [2] = '{4, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key [2];
  logic       press [2];
  logic       abrt [2];
  logic [3:0] scan [2];
  logic [3:0] sense [2];
  logic       busy [2];
  logic       done [2];
  logic       cont [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(4), .BOUNCE_PERIOD(P), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .key_code(key[0]), .press_req(press[0]), .abort(abrt[0]),
    .scan_in(scan[0]), .sense_out(sense[0]), .busy(busy[0]), .done(done[0]), .contact(cont[0]));

  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut0 (
    .clk(clk), .rst(rst), .key_code(key[1]), .press_req(press[1]), .abort(abrt[1]),
    .scan_in(scan[1]), .sense_out(sense[1]), .busy(busy[1]), .done(done[1]), .contact(cont[1]));

  // physical layout: layout[row][col]
  logic [3:0] layout [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

  // model: position k (1-based cycle) within the active press timeline
  bit         m_act [2];
  int         m_k [2];
  logic [3:0] m_key [2];
  bit         m_done [2];

  function automatic logic [3:0] pat(int idx);
    logic [3:0] p;
    p = 4'b1111;
    p[3 - idx] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] row_of(logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) return pat(r);
    return 4'hF;
  endfunction

  function automatic logic [3:0] col_of(logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) return pat(c);
    return 4'hF;
  endfunction

  function automatic bit exp_contact(int i);
    if (!m_act[i]) return 1'b0;
    if (m_k[i] <= BCFG[i]) return (((m_k[i] - 1) / P) % 2) == 0;
    return m_k[i] <= BCFG[i] + H;
  endfunction

  function automatic logic [3:0] exp_sense(int i);
    if (exp_contact(i) && scan[i] == row_of(m_key[i])) return col_of(m_key[i]);
    return 4'hF;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_done[i] = 0; m_key[i] = 4'h0;
    end
  endtask

  task automatic model_edge(int i);
    int t;
    t = BCFG[i] + H + G;
    if (m_act[i]) begin
      if (abrt[i]) begin m_act[i] = 0; m_done[i] = 0; end
      else if (m_k[i] == t) begin m_act[i] = 0; m_done[i] = 1; end
      else begin m_k[i]++; m_done[i] = 0; end
    end else begin
      m_done[i] = 0;
      if (press[i] && !abrt[i]) begin m_act[i] = 1; m_k[i] = 1; m_key[i] = key[i]; end
    end
  endtask

  // one clock: update model from inputs sampled at the edge, then check
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i),    {3'b0, busy[i]}, {3'b0, m_act[i]});
      chk($sformatf("done%0d", i),    {3'b0, done[i]}, {3'b0, m_done[i]});
      chk($sformatf("contact%0d", i), {3'b0, cont[i]}, {3'b0, exp_contact(i)});
      chk($sformatf("sense%0d", i),   sense[i], exp_sense(i));
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      key[i] = 4'h0; press[i] = 0; abrt[i] = 0; scan[i] = 4'hF;
    end
  endtask

  initial begin : main
    logic [3:0] exp1 [13];
    exp1 = '{4'hB, 4'hB, 4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF};
    idle_inputs();
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sense", sense[i], 4'hF);
      chk("rst_busy", {3'b0, busy[i]}, 4'h0);
      chk("rst_done", {3'b0, done[i]}, 4'h0);
      chk("rst_contact", {3'b0, cont[i]}, 4'h0);
    end
    rst = 1'b0;
    step(); step();

    // key 5, row R1 held; explicit timeline, plus late press of key 9 ignored
    key[0] = 4'h5; press[0] = 1; scan[0] = 4'b1011;
    step();
    press[0] = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) step();
      if (c <= 13) chk($sformatf("t1_sense_c%0d", c), sense[0], exp1[c-1]);
      chk($sformatf("t1_done_c%0d", c), {3'b0, done[0]}, {3'b0, c == 14});
      chk($sformatf("t1_busy_c%0d", c), {3'b0, busy[0]}, {3'b0, c <= 13});
      if (c == 3) begin key[0] = 4'h9; press[0] = 1; end
      if (c == 4) press[0] = 0;
    end
    step(); step();

    // full key map with rotating scan rows
    for (int code = 0; code < 16; code++) begin
      key[0] = 4'(code); press[0] = 1;
      for (int c = 0; c < 16; c++) begin
        scan[0] = pat(c % 4);
        step();
        press[0] = 0;
      end
    end

    // key 1 hold: multi-hot, all-high and matching scan
    key[0] = 4'h1; press[0] = 1; scan[0] = 4'hF;
    step(); press[0] = 0;
    repeat (5) step();
    scan[0] = 4'b0011; step(); chk("t3_multihot", sense[0], 4'hF);
    scan[0] = 4'b1111; step(); chk("t3_allhigh", sense[0], 4'hF);
    scan[0] = 4'b0111; step(); chk("t3_match", sense[0], 4'b0111);
    repeat (8) step();

    // abort during hold
    key[0] = 4'h6; press[0] = 1; scan[0] = 4'b1011;
    step(); press[0] = 0;
    repeat (6) step();
    abrt[0] = 1; step(); abrt[0] = 0;
    chk("t5_busy", {3'b0, busy[0]}, 4'h0);
    chk("t5_contact", {3'b0, cont[0]}, 4'h0);
    chk("t5_sense", sense[0], 4'hF);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t5_nodone", {3'b0, done[0]}, 4'h0);
    end

    // abort together with press while idle: request dropped
    key[0] = 4'h2; press[0] = 1; abrt[0] = 1;
    step(); press[0] = 0; abrt[0] = 0;
    chk("abort_wins", {3'b0, busy[0]}, 4'h0);

    // reset mid-hold
    key[0] = 4'h8; press[0] = 1; scan[0] = 4'b1101;
    step(); press[0] = 0;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", {3'b0, busy[0]}, 4'h0);
    chk("t6_contact", {3'b0, cont[0]}, 4'h0);
    chk("t6_sense", sense[0], 4'hF);
    chk("t6_done", {3'b0, done[0]}, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step();

    // no-bounce instance: closed from cycle 1, done at cycle H+G+1
    key[1] = 4'h2; press[1] = 1; scan[1] = 4'b0111;
    step(); press[1] = 0;
    chk("t6_b0_contact_c1", {3'b0, cont[1]}, 4'h1);
    chk("t6_b0_sense_c1", sense[1], 4'b1011);
    for (int c = 2; c <= H + G + 1; c++) begin
      step();
      chk($sformatf("t6_b0_done_c%0d", c), {3'b0, done[1]}, {3'b0, c == H + G + 1});
    end

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        press[i] = ($urandom % 4) == 0;
        key[i]   = 4'($urandom);
        abrt[i]  = ($urandom % 48) == 0;
        scan[i]  = (($urandom % 4) == 0) ? 4'($urandom) : pat(int'($urandom % 4));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
